// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decode/execute/memory status in, register-wall control out.
interface pipeline_hazard_ctrl_if;
    logic [4:0] iID_ra_addr;
    logic [4:0] iID_rb_addr;
    logic       iID_use_ra;
    logic       iID_use_rb;
    logic       iID_do_jump;
    logic       iEX_do_dm_read;
    logic       iEX_do_reg_write;
    logic [4:0] iEX_write_reg_addr;
    logic       iEX_do_branch_taken;
    logic       iIM_ready;
    logic       iDM_request;
    logic       iDM_ready;
    logic       enable_regwalls;
    logic       do_hazard_REG1;
    logic       do_hazard_REG2;
    logic       do_flush_REG1;
    logic       do_pc_hold;
    logic       oTIMEOUT;
    logic [1:0] oSTATE;

    modport master (
        output iID_ra_addr, iID_rb_addr, iID_use_ra, iID_use_rb, iID_do_jump,
               iEX_do_dm_read, iEX_do_reg_write, iEX_write_reg_addr, iEX_do_branch_taken,
               iIM_ready, iDM_request, iDM_ready,
        input  enable_regwalls, do_hazard_REG1, do_hazard_REG2, do_flush_REG1,
               do_pc_hold, oTIMEOUT, oSTATE
    );
    modport slave (
        input  iID_ra_addr, iID_rb_addr, iID_use_ra, iID_use_rb, iID_do_jump,
               iEX_do_dm_read, iEX_do_reg_write, iEX_write_reg_addr, iEX_do_branch_taken,
               iIM_ready, iDM_request, iDM_ready,
        output enable_regwalls, do_hazard_REG1, do_hazard_REG2, do_flush_REG1,
               do_pc_hold, oTIMEOUT, oSTATE
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch/jump flush and memory-wait freeze for the register wall.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int WAIT_TIMEOUT      = 255
) (
    input logic clock,
    input logic reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    localparam logic [3:0] C_STALL = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] C_FLUSH = 4'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_timeout;
    logic       w_wait, w_en, w_br, w_jump, w_luse;
    logic [8:0] w_wait_inc;

    assign w_wait = !bus.iIM_ready | (bus.iDM_request & !bus.iDM_ready);
    assign w_en   = reset & !w_wait;
    assign w_br   = bus.iEX_do_branch_taken;
    assign w_jump = bus.iID_do_jump;
    assign w_luse = bus.iEX_do_dm_read & bus.iEX_do_reg_write & (bus.iEX_write_reg_addr != 5'd0) &
                    ((bus.iID_use_ra & (bus.iID_ra_addr == bus.iEX_write_reg_addr)) |
                     (bus.iID_use_rb & (bus.iID_rb_addr == bus.iEX_write_reg_addr)));
    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

    // Outputs are gated by reset so nothing leaks out while the wall is held.
    assign bus.do_flush_REG1   = reset & (w_br | (r_state == FLUSH));
    assign bus.do_hazard_REG1  = reset & !w_br & w_jump & (r_state == RUN);
    assign bus.do_hazard_REG2  = reset & !w_br & ((r_state == STALL) | ((r_state == RUN) & !w_jump & w_luse));
    assign bus.do_pc_hold      = bus.do_hazard_REG2 | !w_en;
    assign bus.enable_regwalls = w_en;
    assign bus.oTIMEOUT        = r_timeout;
    assign bus.oSTATE          = r_state;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_cnt      <= 4'd0;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else if (w_en) begin
            r_wait_cnt <= 8'd0;
            if (w_br) begin
                r_state <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
                r_cnt   <= C_FLUSH;
            end else if (r_state == RUN) begin
                if (w_luse & !w_jump & (LOAD_STALL_CYCLES > 1)) begin
                    r_state <= STALL;
                    r_cnt   <= C_STALL;
                end
            end else begin
                r_state <= r_cnt == 4'd1 ? RUN : r_state;
                r_cnt   <= r_cnt - 4'd1;
            end
        end else begin
            r_wait_cnt <= r_wait_cnt == 8'hFF ? r_wait_cnt : w_wait_inc[7:0];
            r_timeout  <= r_timeout | (w_wait_inc >= 9'(WAIT_TIMEOUT));
        end
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline control block that drives the stall, bubble, flush and global-enable inputs of the pipeline register wall. It detects load-use hazards between decode and execute, flushes the fetch/decode register after decode-stage jumps and execute-stage taken branches, and freezes the whole pipeline while instruction or data memory is not ready. A watchdog flags memory waits that never complete. It sits between the controller, the register wall and the memory interfaces, and is the producer of the register wall's hazard/flush/enable protocol.

## Interface
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..15)
- FLUSH_CYCLES, 1, cycles REG1 is flushed per execute-stage taken branch (1..15)
- WAIT_TIMEOUT, 255, consecutive frozen cycles before the watchdog trips (1..255)

- clock  in  1  system clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-low reset
- iID_ra_addr  in  5  decode-stage source register A
- iID_rb_addr  in  5  decode-stage source register B
- iID_use_ra  in  1  decode instruction reads register A
- iID_use_rb  in  1  decode instruction reads register B
- iID_do_jump  in  1  decode-stage jump redirect
- iEX_do_dm_read  in  1  execute-stage instruction is a load
- iEX_do_reg_write  in  1  execute-stage instruction writes a register
- iEX_write_reg_addr  in  5  execute-stage destination register
- iEX_do_branch_taken  in  1  execute-stage branch resolved taken
- iIM_ready  in  1  instruction memory has data
- iDM_request  in  1  memory stage is reading or writing data memory
- iDM_ready  in  1  data memory access complete
- enable_regwalls  out  1  pipeline advance enable
- do_hazard_REG1  out  1  zero REG1 (decode jump)
- do_hazard_REG2  out  1  hold REG1, bubble REG2 (load-use)
- do_flush_REG1  out  1  zero REG1 (taken branch)
- do_pc_hold  out  1  PC must not advance
- oTIMEOUT  out  1  sticky watchdog flag
- oSTATE  out  2  00 RUN, 01 STALL, 10 FLUSH

## Operation
- wait = !iIM_ready | (iDM_request & !iDM_ready); enable_regwalls = reset & !wait.
- luse = iEX_do_dm_read & iEX_do_reg_write & (iEX_write_reg_addr != 0) & ((iID_use_ra & iID_ra_addr == iEX_write_reg_addr) | (iID_use_rb & iID_rb_addr == iEX_write_reg_addr)).
- Priority when enabled: taken branch > jump > load-use. do_hazard_REG2 and do_flush_REG1/do_hazard_REG1 are never asserted together.
- RUN: iEX_do_branch_taken -> do_flush_REG1=1; if FLUSH_CYCLES>1 go FLUSH with count=FLUSH_CYCLES-1. Else iID_do_jump -> do_hazard_REG1=1 (one cycle, no state change). Else luse -> do_hazard_REG2=1; if LOAD_STALL_CYCLES>1 go STALL with count=LOAD_STALL_CYCLES-1.
- STALL: do_hazard_REG2=1; count decrements; at count==1 return to RUN. Taken branch in STALL: abort stall, act as in RUN.
- FLUSH: do_flush_REG1=1; count decrements; at count==1 return to RUN. Taken branch in FLUSH reloads count=FLUSH_CYCLES-1 (stays FLUSH if >0). Jump/luse ignored.
- do_pc_hold = do_hazard_REG2 | !enable_regwalls.
- While enable_regwalls=0: state and count frozen; hazard/flush outputs still computed but ignored downstream; events persist because stages are frozen.
- Watchdog: 8-bit wait counter increments each frozen cycle, clears on any enabled cycle; reaching WAIT_TIMEOUT sets oTIMEOUT, cleared only by reset. Counter saturates.
- Register 0 never causes a hazard.

## Timing
- Reset (reset=0, asynchronous): state RUN, counters 0, oTIMEOUT=0, oSTATE=00; enable_regwalls=0, all hazard/flush outputs 0, do_pc_hold=1.
- Hazard, flush, enable and do_pc_hold outputs are combinational from state and inputs, valid before the falling edge at which the register wall samples them; zero added latency.
- State, count, watchdog update on the falling edge of clock.
- Load-use costs exactly LOAD_STALL_CYCLES enabled cycles; taken branch exactly FLUSH_CYCLES enabled cycles; frozen cycles do not count.
- Reset asserted mid-STALL/FLUSH: immediate return to RUN, no residual outputs after release.

## Test plan
- Load to r5 in EX, decode uses r5 as B (use_rb=1), LOAD_STALL_CYCLES=1 -> do_hazard_REG2=1, do_pc_hold=1 for one cycle, oSTATE stays 00; same with dest r0 -> no stall.
- LOAD_STALL_CYCLES=3, luse, iDM_ready low 2 cycles during stall -> do_hazard_REG2 high 3 enabled cycles plus 2 frozen, enable_regwalls low exactly 2.
- Branch taken with simultaneous luse, FLUSH_CYCLES=2 -> do_flush_REG1=1 two cycles, do_hazard_REG2=0 throughout, oSTATE 00->10->00.
- iID_do_jump with no branch -> do_hazard_REG1=1 one cycle; jump plus branch taken -> only do_flush_REG1.
- iIM_ready=0 for 255 cycles, WAIT_TIMEOUT=255 -> oTIMEOUT=1 after 255th frozen falling edge, stays 1 after iIM_ready returns until reset.
- reset pulsed low during FLUSH count=5 -> outputs return to reset values immediately, oSTATE=00 after release.
